// File: rtl/tlb_pkg.sv
// Shared TLB constants and virtual/physical address field helpers.
// Used by tlb_way and by the parent TLB that replicates it per way.
package tlb_pkg;

  localparam int unsigned SADDR = 64;
  localparam int unsigned SPAGE = 12;
  localparam int unsigned NSET  = 8;
  localparam int unsigned SPCID = 12;

  localparam int unsigned SIDX = $clog2(NSET);
  localparam int unsigned STAG = SADDR - SPAGE - SIDX;
  localparam int unsigned SPPN = SADDR - SPAGE;

  function automatic logic [SIDX-1:0] va_set(input logic [SADDR-1:0] va);
    return va[SPAGE +: SIDX];
  endfunction

  function automatic logic [STAG-1:0] va_tag(input logic [SADDR-1:0] va);
    return va[SADDR-1 -: STAG];
  endfunction

  function automatic logic [SPPN-1:0] pa_ppn(input logic [SADDR-1:0] pa);
    return pa[SADDR-1 -: SPPN];
  endfunction

endpackage

// File: rtl/tlb_way.sv
// One TLB way: per-set {valid, tag, pcid, ppn} registers with a combinational
// lookup and a single clocked write port. Replacement lives in the parent.
module tlb_way #(
  parameter int unsigned SADDR = tlb_pkg::SADDR,
  parameter int unsigned SPAGE = tlb_pkg::SPAGE,
  parameter int unsigned NSET  = tlb_pkg::NSET,
  parameter int unsigned SPCID = tlb_pkg::SPCID,
  localparam int unsigned SIDX = $clog2(NSET),
  localparam int unsigned STAG = SADDR - SPAGE - SIDX,
  localparam int unsigned SPPN = SADDR - SPAGE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shutdown,
  input  logic [SIDX-1:0]  rd_set,
  input  logic [STAG-1:0]  rd_tag,
  input  logic [SPCID-1:0] rd_pcid,
  output logic             hit,
  output logic [SPPN-1:0]  ppn,
  input  logic             wr_en,
  input  logic [SIDX-1:0]  wr_set,
  input  logic [STAG-1:0]  wr_tag,
  input  logic [SPCID-1:0] wr_pcid,
  input  logic [SPPN-1:0]  wr_ppn
);

  logic [NSET-1:0]  valid_q, valid_d;
  logic [STAG-1:0]  tag_q  [NSET];
  logic [STAG-1:0]  tag_d  [NSET];
  logic [SPCID-1:0] pcid_q [NSET];
  logic [SPCID-1:0] pcid_d [NSET];
  logic [SPPN-1:0]  ppn_q  [NSET];
  logic [SPPN-1:0]  ppn_d  [NSET];

  // Flush zeroes every field, not just valid, and drops a coincident write.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    pcid_d  = pcid_q;
    ppn_d   = ppn_q;
    if (shutdown) begin
      valid_d = '0;
      tag_d   = '{default: '0};
      pcid_d  = '{default: '0};
      ppn_d   = '{default: '0};
    end else if (wr_en) begin
      valid_d[wr_set] = 1'b1;
      tag_d[wr_set]   = wr_tag;
      pcid_d[wr_set]  = wr_pcid;
      ppn_d[wr_set]   = wr_ppn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      pcid_q  <= '{default: '0};
      ppn_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      pcid_q  <= pcid_d;
      ppn_q   <= ppn_d;
    end
  end

  // Lookup reads registered state only, so a same-cycle write is not visible.
  always_comb begin
    hit = valid_q[rd_set] && (tag_q[rd_set] == rd_tag) && (pcid_q[rd_set] == rd_pcid);
    ppn = hit ? ppn_q[rd_set] : '0;
  end

endmodule

// File: tb/tb_tlb_way.sv
// Directed self-checking bench for tlb_way.
module tb_tlb_way;
  import tlb_pkg::*;

  logic             clk;
  logic             rst;
  logic             shutdown;
  logic [SIDX-1:0]  rd_set;
  logic [STAG-1:0]  rd_tag;
  logic [SPCID-1:0] rd_pcid;
  logic             hit;
  logic [SPPN-1:0]  ppn;
  logic             wr_en;
  logic [SIDX-1:0]  wr_set;
  logic [STAG-1:0]  wr_tag;
  logic [SPCID-1:0] wr_pcid;
  logic [SPPN-1:0]  wr_ppn;

  int errors = 0;
  int checks = 0;

  tlb_way dut (
    .clk      (clk),
    .rst      (rst),
    .shutdown (shutdown),
    .rd_set   (rd_set),
    .rd_tag   (rd_tag),
    .rd_pcid  (rd_pcid),
    .hit      (hit),
    .ppn      (ppn),
    .wr_en    (wr_en),
    .wr_set   (wr_set),
    .wr_tag   (wr_tag),
    .wr_pcid  (wr_pcid),
    .wr_ppn   (wr_ppn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [SIDX-1:0] s, input logic [STAG-1:0] t,
                      input logic [SPCID-1:0] p);
    rd_set  = s;
    rd_tag  = t;
    rd_pcid = p;
    #1;
  endtask

  task automatic write(input logic [SIDX-1:0] s, input logic [STAG-1:0] t,
                       input logic [SPCID-1:0] p, input logic [SPPN-1:0] n);
    wr_en   = 1'b1;
    wr_set  = s;
    wr_tag  = t;
    wr_pcid = p;
    wr_ppn  = n;
    tick();
    wr_en = 1'b0;
  endtask

  localparam logic [STAG-1:0] TagA = 49'h1_2345_6789_ABC;
  localparam logic [SPPN-1:0] PpnA = 52'hF_0000_1234_5;

  initial begin
    logic [SADDR-1:0] va;
    rst = 1'b1; shutdown = 1'b0; wr_en = 1'b0;
    wr_set = '0; wr_tag = '0; wr_pcid = '0; wr_ppn = '0;
    rd_set = '0; rd_tag = '0; rd_pcid = '0;

    // Reset held, before any clock edge.
    #2;
    chk("rst_hit", {63'd0, hit}, 64'd0);
    chk("rst_ppn", {12'd0, ppn}, 64'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      look(i[SIDX-1:0], '0, '0);
      chk($sformatf("post_rst_hit_set%0d", i), {63'd0, hit}, 64'd0);
    end

    // Write set 3, look it up via a VA built from the same fields.
    write(3'd3, TagA, 12'h05A, PpnA);
    va = {TagA, 3'd3, 12'h5A5};
    look(va_set(va), va_tag(va), 12'h05A);
    chk("wr_hit", {63'd0, hit}, 64'd1);
    chk("wr_ppn", {12'd0, ppn}, {12'd0, PpnA});
    look(3'd2, TagA, 12'h05A);
    chk("other_set_hit", {63'd0, hit}, 64'd0);

    // PCID and tag mismatch.
    look(3'd3, TagA, 12'h05B);
    chk("pcid_mis_hit", {63'd0, hit}, 64'd0);
    chk("pcid_mis_ppn", {12'd0, ppn}, 64'd0);
    look(3'd3, TagA + 49'd1, 12'h05A);
    chk("tag_mis_hit", {63'd0, hit}, 64'd0);

    // Read-during-write to set 5: old contents that cycle, new afterwards.
    write(3'd5, 49'h0AAAA, 12'h001, 52'h1111);
    look(3'd5, 49'h0AAAA, 12'h001);
    chk("rdw_a_hit", {63'd0, hit}, 64'd1);
    wr_en = 1'b1; wr_set = 3'd5; wr_tag = 49'h0BBBB; wr_pcid = 12'h001; wr_ppn = 52'h2222;
    look(3'd5, 49'h0BBBB, 12'h001);
    chk("rdw_same_cycle_hit", {63'd0, hit}, 64'd0);
    tick();
    wr_en = 1'b0;
    look(3'd5, 49'h0BBBB, 12'h001);
    chk("rdw_next_hit", {63'd0, hit}, 64'd1);
    chk("rdw_next_ppn", {12'd0, ppn}, 64'h2222);
    look(3'd5, 49'h0AAAA, 12'h001);
    chk("rdw_old_miss", {63'd0, hit}, 64'd0);

    // Fill all sets, then flush with a coincident write to set 1.
    for (int i = 0; i < 8; i++)
      write(i[SIDX-1:0], 49'h100 + 49'(i), 12'(i), 52'h200 + 52'(i));
    look(3'd6, 49'h106, 12'd6);
    chk("fill_hit", {63'd0, hit}, 64'd1);
    chk("fill_ppn", {12'd0, ppn}, 64'h206);
    shutdown = 1'b1;
    wr_en = 1'b1; wr_set = 3'd1; wr_tag = 49'h777; wr_pcid = 12'h007; wr_ppn = 52'h777;
    look(3'd0, 49'h100, 12'd0);
    chk("flush_cycle_hit", {63'd0, hit}, 64'd1);
    tick();
    shutdown = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      look(i[SIDX-1:0], 49'h100 + 49'(i), 12'(i));
      chk($sformatf("flush_miss_set%0d", i), {63'd0, hit}, 64'd0);
    end
    look(3'd1, 49'h777, 12'h007);
    chk("flush_drop_wr", {63'd0, hit}, 64'd0);
    look(3'd2, '0, '0);
    chk("flush_zero_hit", {63'd0, hit}, 64'd0);
    chk("flush_zero_ppn", {12'd0, ppn}, 64'd0);

    // Async reset between edges.
    for (int i = 0; i < 8; i++)
      write(i[SIDX-1:0], 49'h300 + 49'(i), 12'h0F0, 52'h400 + 52'(i));
    look(3'd4, 49'h304, 12'h0F0);
    chk("pre_arst_hit", {63'd0, hit}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hit", {63'd0, hit}, 64'd0);
    chk("arst_ppn", {12'd0, ppn}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      look(i[SIDX-1:0], 49'h300 + 49'(i), 12'h0F0);
      chk($sformatf("arst_miss_set%0d", i), {63'd0, hit}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
